// File: rtl/ad9910_cmd_seq_if.sv
// Command stream between the RTMQ core and the AD9910 command sequencer.
// The core drives a command and valid; the sequencer answers with ready.
interface ad9910_cmd_seq_if;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [2:0]  cmd_typ;
   logic [4:0]  cmd_adr;
   logic [1:0]  cmd_len;
   logic [63:0] cmd_dat;

   modport master (
      output cmd_vld, cmd_typ, cmd_adr, cmd_len, cmd_dat,
      input  cmd_rdy
   );

   modport slave (
      input  cmd_vld, cmd_typ, cmd_adr, cmd_len, cmd_dat,
      output cmd_rdy
   );
endinterface

// File: rtl/ad9910_cmd_seq.sv
// AD9910 channel command sequencer: SPI register writes, io_upd/io_rst/m_rst
// pulses, profile selection and programmable waits driven onto the cdds bus.
module ad9910_cmd_seq #(
   parameter int CLK_DIV = 4,
   parameter int T_UPD   = 4,
   parameter int T_MRST  = 16
) (
   input  logic                clk,
   input  logic                rst,
   ad9910_cmd_seq_if.slave     cmd,
   input  logic [3:0]          pbk_ctl,
   output logic [12:0]         cdds,
   output logic                spi_csb,
   output logic                spi_sclk,
   output logic                spi_sdio,
   output logic                busy
);

   typedef enum logic [2:0] {IDLE, SHIFT, HOLD, PULSE, WAIT, GAP} state_t;
   typedef enum logic [1:0] {P_UPD, P_IORST, P_MRST} pulse_t;

   localparam logic [31:0] DIV      = 32'(CLK_DIV);
   localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);
   localparam logic [31:0] BIT_LAST = 32'(2 * CLK_DIV - 1);
   localparam logic [31:0] UPD_LAST = 32'(T_UPD - 1);
   localparam logic [31:0] MRS_LAST = 32'(T_MRST - 1);

   state_t      state_reg, state_next;
   pulse_t      pulse_reg, pulse_next;
   logic [31:0] cnt_reg, cnt_next;
   logic [6:0]  bit_reg, bit_next;
   logic [71:0] shift_reg, shift_next;
   logic [2:0]  prof_reg, prof_next;
   logic [1:0]  pf_reg, pf_next;
   logic        txen_reg, txen_next;
   logic [3:0]  pbk_reg;
   logic        io_upd_reg, io_upd_next;
   logic        io_rst_reg, io_rst_next;
   logic        m_rst_reg, m_rst_next;
   logic        csb_reg, csb_next;
   logic        sclk_reg, sclk_next;
   logic        sdio_reg, sdio_next;

   logic        rdy;
   logic        accept;
   logic [71:0] frame;
   logic [6:0]  frame_last;

   assign rdy         = (state_reg == IDLE) && !rst;
   assign accept      = cmd.cmd_vld && rdy;
   assign cmd.cmd_rdy = rdy;
   assign busy        = ~rdy;

   // Frame is left-justified so the shifter always emits bit 71 first.
   always_comb begin
      frame      = '0;
      frame_last = 7'd15;
      case (cmd.cmd_len)
         2'd0: begin frame = {3'b000, cmd.cmd_adr, cmd.cmd_dat[7:0], 56'd0};  frame_last = 7'd15; end
         2'd1: begin frame = {3'b000, cmd.cmd_adr, cmd.cmd_dat[15:0], 48'd0}; frame_last = 7'd23; end
         2'd2: begin frame = {3'b000, cmd.cmd_adr, cmd.cmd_dat[31:0], 32'd0}; frame_last = 7'd39; end
         default: begin frame = {3'b000, cmd.cmd_adr, cmd.cmd_dat};          frame_last = 7'd71; end
      endcase
   end

   always_comb begin
      state_next = state_reg;
      pulse_next = pulse_reg;
      cnt_next   = cnt_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      prof_next  = prof_reg;
      pf_next    = pf_reg;
      txen_next  = txen_reg;
      unique case (state_reg)
         IDLE: begin
            if (accept) begin
               case (cmd.cmd_typ)
                  3'd0: begin
                     state_next = SHIFT;
                     cnt_next   = BIT_LAST;
                     bit_next   = frame_last;
                     shift_next = frame;
                  end
                  3'd1: begin state_next = PULSE; pulse_next = P_UPD;   cnt_next = UPD_LAST; end
                  3'd2: begin
                     state_next = WAIT;
                     cnt_next   = '0;
                     pf_next    = cmd.cmd_dat[1:0];
                     prof_next  = cmd.cmd_dat[4:2];
                     txen_next  = cmd.cmd_dat[5];
                  end
                  3'd3: begin
                     state_next = PULSE;
                     pulse_next = P_MRST;
                     cnt_next   = MRS_LAST;
                     pf_next    = '0;
                     prof_next  = '0;
                     txen_next  = 1'b0;
                  end
                  3'd4: begin state_next = PULSE; pulse_next = P_IORST; cnt_next = UPD_LAST; end
                  3'd5: begin
                     state_next = WAIT;
                     cnt_next   = (cmd.cmd_dat[31:0] == 32'd0) ? 32'd0 : cmd.cmd_dat[31:0] - 32'd1;
                  end
                  default: begin state_next = WAIT; cnt_next = '0; end
               endcase
            end
         end
         SHIFT: begin
            if (cnt_reg != 32'd0) begin
               cnt_next = cnt_reg - 32'd1;
            end else if (bit_reg == 7'd0) begin
               state_next = HOLD;
               cnt_next   = DIV_LAST;
            end else begin
               bit_next   = bit_reg - 7'd1;
               shift_next = {shift_reg[70:0], 1'b0};
               cnt_next   = BIT_LAST;
            end
         end
         HOLD, PULSE: begin
            if (cnt_reg != 32'd0) begin
               cnt_next = cnt_reg - 32'd1;
            end else begin
               state_next = GAP;
               cnt_next   = DIV_LAST;
            end
         end
         WAIT, GAP: begin
            if (cnt_reg != 32'd0) cnt_next = cnt_reg - 32'd1;
            else                  state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Pin values are decoded from the next state so they can be registered
      // without adding a cycle of latency.
      csb_next    = !(state_next == SHIFT || state_next == HOLD);
      sclk_next   = (state_next == SHIFT) && (cnt_next < DIV);
      sdio_next   = (state_next == SHIFT) && shift_next[71];
      io_upd_next = (state_next == PULSE) && (pulse_next == P_UPD);
      io_rst_next = (state_next == PULSE) && (pulse_next == P_IORST);
      m_rst_next  = (state_next == PULSE) && (pulse_next == P_MRST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         pulse_reg  <= P_UPD;
         cnt_reg    <= '0;
         bit_reg    <= '0;
         shift_reg  <= '0;
         prof_reg   <= '0;
         pf_reg     <= '0;
         txen_reg   <= 1'b0;
         pbk_reg    <= '0;
         io_upd_reg <= 1'b0;
         io_rst_reg <= 1'b0;
         m_rst_reg  <= 1'b0;
         csb_reg    <= 1'b1;
         sclk_reg   <= 1'b0;
         sdio_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pulse_reg  <= pulse_next;
         cnt_reg    <= cnt_next;
         bit_reg    <= bit_next;
         shift_reg  <= shift_next;
         prof_reg   <= prof_next;
         pf_reg     <= pf_next;
         txen_reg   <= txen_next;
         pbk_reg    <= pbk_ctl;
         io_upd_reg <= io_upd_next;
         io_rst_reg <= io_rst_next;
         m_rst_reg  <= m_rst_next;
         csb_reg    <= csb_next;
         sclk_reg   <= sclk_next;
         sdio_reg   <= sdio_next;
      end
   end

   assign cdds     = {txen_reg, pbk_reg, io_rst_reg, m_rst_reg, io_upd_reg, prof_reg, pf_reg};
   assign spi_csb  = csb_reg;
   assign spi_sclk = sclk_reg;
   assign spi_sdio = sdio_reg;

endmodule

// File: tb/tb_ad9910_cmd_seq.sv
// Directed and random command stream for ad9910_cmd_seq, checked cycle by
// cycle against a command-level model of durations, frames and held fields.
module tb_ad9910_cmd_seq;
   localparam int D  = 4;
   localparam int TU = 4;
   localparam int TM = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  pbk_ctl = 4'd0;
   logic [12:0] cdds;
   logic        spi_csb, spi_sclk, spi_sdio, busy;

   ad9910_cmd_seq_if bus();

   ad9910_cmd_seq #(.CLK_DIV(D), .T_UPD(TU), .T_MRST(TM)) dut (
      .clk(clk), .rst(rst), .cmd(bus), .pbk_ctl(pbk_ctl), .cdds(cdds),
      .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_sdio(spi_sdio), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [2:0] m_prof = '0;
   logic [1:0] m_pf   = '0;
   logic       m_txen = 1'b0;
   logic [3:0] m_pbk  = '0;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_dur(input logic [2:0] typ, input logic [1:0] len, input logic [63:0] dat);
      int n;
      n = 8 << len;
      case (typ)
         3'd0: return (8 + n) * 2 * D + 2 * D;
         3'd1: return TU + D;
         3'd3: return TM + D;
         3'd4: return TU + D;
         3'd5: return (dat[31:0] == 32'd0) ? 1 : int'(dat[31:0]);
         default: return 1;
      endcase
   endfunction

   // Issue one command, then watch every busy cycle until ready returns.
   task automatic run_cmd(input logic [2:0] typ, input logic [4:0] adr,
                          input logic [1:0] len, input logic [63:0] dat);
      int guard, busy_n, csb_low, n_upd, n_iorst, n_mrst, rises, n;
      int held_err, sdio_err, excl_err;
      logic [71:0] bits, frame;
      logic [63:0] mask;
      logic prev_sclk, done;
      logic [3:0] pbk_new;
      guard = 0;
      while (!bus.cmd_rdy && guard < 2000) begin @(negedge clk); guard++; end
      chk("rdy_before_cmd", 72'(bus.cmd_rdy), 72'd1);
      pbk_new = 4'($urandom);
      pbk_ctl = pbk_new;
      bus.cmd_typ = typ; bus.cmd_adr = adr; bus.cmd_len = len; bus.cmd_dat = dat;
      bus.cmd_vld = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_vld = 1'b0;
      bus.cmd_typ = 3'($urandom); bus.cmd_adr = 5'($urandom);
      bus.cmd_len = 2'($urandom); bus.cmd_dat = {$urandom, $urandom};
      m_pbk = pbk_new;
      if (typ == 3'd2) begin m_pf = dat[1:0]; m_prof = dat[4:2]; m_txen = dat[5]; end
      if (typ == 3'd3) begin m_pf = '0; m_prof = '0; m_txen = 1'b0; end
      n = 8 << len;
      mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
      frame = (72'(adr) << n) | 72'(dat & mask);
      busy_n = 0; csb_low = 0; n_upd = 0; n_iorst = 0; n_mrst = 0; rises = 0;
      held_err = 0; sdio_err = 0; excl_err = 0; bits = '0; prev_sclk = 1'b0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (bus.cmd_rdy || busy_n >= 2000) begin
            done = 1'b1;
         end else begin
            busy_n++;
            if (!spi_csb) csb_low++;
            if (cdds[5]) n_upd++;
            if (cdds[7]) n_iorst++;
            if (cdds[6]) n_mrst++;
            if (int'(cdds[5]) + int'(cdds[6]) + int'(cdds[7]) > 1 || !busy) excl_err++;
            if (spi_csb && (spi_sdio || spi_sclk)) sdio_err++;
            if (cdds[4:0] !== {m_prof, m_pf} || cdds[12] !== m_txen || cdds[11:8] !== m_pbk) held_err++;
            if (spi_sclk && !prev_sclk) begin rises++; bits = {bits[70:0], spi_sdio}; end
            prev_sclk = spi_sclk;
         end
      end
      $display("cmd typ=%0d adr=%0h len=%0d dat=%0h busy=%0d csb_low=%0d rises=%0d",
               typ, adr, len, dat, busy_n, csb_low, rises);
      chk("busy_cycles", 72'(busy_n), 72'(exp_dur(typ, len, dat)));
      chk("csb_low_cycles", 72'(csb_low), (typ == 3'd0) ? 72'((8 + n) * 2 * D + D) : 72'd0);
      chk("io_upd_cycles", 72'(n_upd), (typ == 3'd1) ? 72'(TU) : 72'd0);
      chk("io_rst_cycles", 72'(n_iorst), (typ == 3'd4) ? 72'(TU) : 72'd0);
      chk("m_rst_cycles", 72'(n_mrst), (typ == 3'd3) ? 72'(TM) : 72'd0);
      chk("held_fields", 72'(held_err), 72'd0);
      chk("idle_pins_and_excl", 72'(sdio_err + excl_err), 72'd0);
      chk("pins_at_ready", 72'({spi_csb, spi_sclk, spi_sdio, cdds[7:5]}), 72'b100000);
      if (typ == 3'd0) begin
         chk("sclk_rises", 72'(rises), 72'(8 + n));
         chk("spi_frame", bits, frame);
      end
   endtask

   initial begin
      int rises;
      logic prev;
      bus.cmd_vld = 1'b1; bus.cmd_typ = 3'd1; bus.cmd_adr = '0; bus.cmd_len = '0; bus.cmd_dat = '0;

      // Reset with a pending command that must not be taken.
      repeat (3) @(negedge clk);
      chk("rst_cdds", 72'(cdds), 72'd0);
      chk("rst_pins", 72'({spi_csb, spi_sclk, spi_sdio}), 72'b100);
      chk("rst_rdy", 72'({bus.cmd_rdy, busy}), 72'b01);
      bus.cmd_vld = 1'b0;
      rst = 1'b0;
      pbk_ctl = 4'b1010;
      #1;
      chk("rdy_after_rst", 72'(bus.cmd_rdy), 72'd1);
      chk("cdds_after_rst", 72'(cdds), 72'd0);
      @(negedge clk);
      chk("pbk_delayed", 72'(cdds), 72'(13'b0_1010_0000_0000));
      m_pbk = 4'b1010;

      run_cmd(3'd0, 5'h0E, 2'd2, 64'hA5F0_0F5A);
      run_cmd(3'd2, 5'h00, 2'd0, 64'b101110);
      chk("profile_fields", 72'({cdds[12], cdds[4:0]}), 72'b1_011_10);
      run_cmd(3'd1, 5'h00, 2'd0, 64'd0);
      run_cmd(3'd3, 5'h00, 2'd0, 64'd0);
      run_cmd(3'd5, 5'h00, 2'd0, 64'd0);
      run_cmd(3'd5, 5'h00, 2'd0, 64'd100);
      run_cmd(3'd7, 5'h1F, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
      run_cmd(3'd4, 5'h00, 2'd0, 64'd0);
      run_cmd(3'd0, 5'h1F, 2'd0, 64'h0000_0000_0000_0081);
      run_cmd(3'd0, 5'h15, 2'd3, 64'hDEAD_BEEF_0123_4567);

      for (int i = 0; i < 30; i++) begin
         logic [2:0] t;
         logic [63:0] d;
         t = 3'($urandom_range(0, 7));
         d = (t == 3'd5) ? 64'($urandom_range(0, 40)) : {$urandom, $urandom};
         run_cmd(t, 5'($urandom), 2'($urandom), d);
      end

      // Abort a long write partway through with reset.
      run_cmd(3'd2, 5'h00, 2'd0, 64'b111111);
      bus.cmd_typ = 3'd0; bus.cmd_adr = 5'h0B; bus.cmd_len = 2'd3; bus.cmd_dat = {$urandom, $urandom};
      bus.cmd_vld = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_vld = 1'b0;
      rises = 0; prev = 1'b0;
      for (int c = 0; c < 2000 && rises < 20; c++) begin
         @(negedge clk);
         if (spi_sclk && !prev) rises++;
         prev = spi_sclk;
      end
      chk("abort_reached_bit20", 72'(rises), 72'd20);
      rst = 1'b1;
      @(negedge clk);
      $display("abort write at bit %0d: csb=%0b sclk=%0b cdds=%0h", rises, spi_csb, spi_sclk, cdds);
      chk("abort_pins", 72'({spi_csb, spi_sclk, spi_sdio}), 72'b100);
      chk("abort_cdds", 72'(cdds), 72'd0);
      chk("abort_rdy", 72'(bus.cmd_rdy), 72'd0);
      rst = 1'b0;
      #1;
      chk("abort_rdy_after", 72'(bus.cmd_rdy), 72'd1);
      m_prof = '0; m_pf = '0; m_txen = 1'b0;
      run_cmd(3'd1, 5'h00, 2'd0, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
